// File: rtl/usb_cdc_fifo_ex.sv
// usb_cdc_fifo_ex: parametrised synchronous FIFO for the USB CDC data path.
// Provides a level count, threshold flags, synchronous flush, sticky
// overflow/underflow errors and a selectable FWFT or registered read port.
module usb_cdc_fifo_ex #(
    parameter int DW   = 8,
    parameter int AW   = 4,
    parameter int FWFT = 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          flush,
    input  logic          wr,
    input  logic [DW-1:0] w_data,
    input  logic          rd,
    output logic [DW-1:0] r_data,
    output logic          r_valid,
    output logic          empty,
    output logic          full,
    output logic [AW:0]   level,
    input  logic [AW:0]   th,
    output logic          level_above,
    output logic          level_below,
    output logic          overflow,
    output logic          underflow,
    input  logic          err_clr
);

    localparam int          DEPTH    = 1 << AW;
    localparam logic [AW:0] LVL_FULL = (AW+1)'(DEPTH);
    localparam logic [AW:0] LVL_ONE  = (AW+1)'(1);
    localparam logic [AW-1:0] PTR_ONE = AW'(1);

    logic [DW-1:0] r_mem [DEPTH];
    logic [AW-1:0] r_wptr;
    logic [AW-1:0] r_rptr;
    logic [AW:0]   r_level;
    logic          r_ovf;
    logic          r_unf;

    logic w_empty;
    logic w_full;
    logic w_rd_acc;
    logic w_wr_acc;
    logic w_ovf_set;
    logic w_unf_set;

    // Status flags come only from the registered level; a write while full
    // is accepted only when it is paired with an accepted read.
    always_comb begin
        w_empty   = (r_level == '0);
        w_full    = (r_level == LVL_FULL);
        w_rd_acc  = rd & ~w_empty;
        w_wr_acc  = wr & (~w_full | w_rd_acc);
        w_ovf_set = wr & ~w_wr_acc & ~flush;
        w_unf_set = rd & ~w_rd_acc & ~flush;
    end

    // Storage array: written on an accepted write, never reset.
    always_ff @(posedge clk) begin
        if (w_wr_acc && !flush) begin
            r_mem[r_wptr] <= w_data;
        end
    end

    // Pointers and level; flush overrides any transfer in the same cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_level <= '0;
        end else if (flush) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_level <= '0;
        end else begin
            if (w_wr_acc) begin
                r_wptr <= r_wptr + PTR_ONE;
            end
            if (w_rd_acc) begin
                r_rptr <= r_rptr + PTR_ONE;
            end
            if (w_wr_acc && !w_rd_acc) begin
                r_level <= r_level + LVL_ONE;
            end else if (!w_wr_acc && w_rd_acc) begin
                r_level <= r_level - LVL_ONE;
            end
        end
    end

    // Sticky error flags: a new rejection wins over err_clr; flush leaves them alone.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ovf <= 1'b0;
            r_unf <= 1'b0;
        end else begin
            if (w_ovf_set) begin
                r_ovf <= 1'b1;
            end else if (err_clr) begin
                r_ovf <= 1'b0;
            end
            if (w_unf_set) begin
                r_unf <= 1'b1;
            end else if (err_clr) begin
                r_unf <= 1'b0;
            end
        end
    end

    generate
        if (FWFT != 0) begin : g_fwft
            // Head word is shown directly; rd acknowledges the displayed word.
            always_comb begin
                r_data  = r_mem[r_rptr];
                r_valid = ~w_empty;
            end
        end else begin : g_reg
            logic [DW-1:0] r_rd_data;
            logic          r_rd_vld;

            // Registered read port: data lands one cycle after the accepted read.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_rd_data <= '0;
                    r_rd_vld  <= 1'b0;
                end else if (flush) begin
                    r_rd_vld  <= 1'b0;
                end else begin
                    r_rd_vld <= w_rd_acc;
                    if (w_rd_acc) begin
                        r_rd_data <= r_mem[r_rptr];
                    end
                end
            end

            // Drive the port from the registered copy.
            always_comb begin
                r_data  = r_rd_data;
                r_valid = r_rd_vld;
            end
        end
    endgenerate

    // Output mapping and unsigned threshold compares on the registered level.
    always_comb begin
        empty       = w_empty;
        full        = w_full;
        level       = r_level;
        level_above = (r_level > th);
        level_below = (r_level < th);
        overflow    = r_ovf;
        underflow   = r_unf;
    end

endmodule

// File: tb/tb_usb_cdc_fifo_ex.sv
// Testbench for usb_cdc_fifo_ex: one FWFT and one registered-read instance
// share the same stimulus and are compared against a queue-based model.
module tb_usb_cdc_fifo_ex;

    localparam int DW    = 8;
    localparam int AW    = 4;
    localparam int DEPTH = 16;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          flush;
    logic          wr;
    logic [DW-1:0] w_data;
    logic          rd;
    logic [AW:0]   th;
    logic          err_clr;

    logic [DW-1:0] r_data1, r_data0;
    logic          r_valid1, r_valid0;
    logic          empty1, empty0, full1, full0;
    logic [AW:0]   level1, level0;
    logic          above1, above0, below1, below0;
    logic          ovf1, ovf0, unf1, unf0;

    int tests = 0;
    int fails = 0;

    // Reference model state
    logic [DW-1:0] q[$];
    bit            m_ovf, m_unf, m_v0;
    logic [DW-1:0] m_d0;

    always #5 clk = ~clk;

    usb_cdc_fifo_ex #(.DW(DW), .AW(AW), .FWFT(1)) u_dut (
        .clk(clk), .rst_n(rst_n), .flush(flush), .wr(wr), .w_data(w_data),
        .rd(rd), .r_data(r_data1), .r_valid(r_valid1), .empty(empty1),
        .full(full1), .level(level1), .th(th), .level_above(above1),
        .level_below(below1), .overflow(ovf1), .underflow(unf1), .err_clr(err_clr)
    );

    usb_cdc_fifo_ex #(.DW(DW), .AW(AW), .FWFT(0)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .flush(flush), .wr(wr), .w_data(w_data),
        .rd(rd), .r_data(r_data0), .r_valid(r_valid0), .empty(empty0),
        .full(full0), .level(level0), .th(th), .level_above(above0),
        .level_below(below0), .overflow(ovf0), .underflow(unf0), .err_clr(err_clr)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        int n;
        n = q.size();
        chk("level",       32'(level1), 32'(n));
        chk("level_reg",   32'(level0), 32'(n));
        chk("empty",       32'(empty1), 32'(n == 0));
        chk("empty_reg",   32'(empty0), 32'(n == 0));
        chk("full",        32'(full1),  32'(n == DEPTH));
        chk("full_reg",    32'(full0),  32'(n == DEPTH));
        chk("level_above", 32'(above1), 32'(n > int'(th)));
        chk("level_below", 32'(below1), 32'(n < int'(th)));
        chk("overflow",    32'(ovf1),   32'(m_ovf));
        chk("underflow",   32'(unf1),   32'(m_unf));
        chk("overflow_reg",  32'(ovf0), 32'(m_ovf));
        chk("underflow_reg", 32'(unf0), 32'(m_unf));
        chk("r_valid_fwft", 32'(r_valid1), 32'(n != 0));
        if (n != 0) chk("r_data_fwft", 32'(r_data1), 32'(q[0]));
        chk("r_valid_reg", 32'(r_valid0), 32'(m_v0));
        chk("r_data_reg",  32'(r_data0),  32'(m_d0));
    endtask

    // Drive one cycle from a falling edge, check, then advance the model.
    task automatic cycle(input bit w, input logic [DW-1:0] d, input bit r,
                         input bit f, input bit e);
        bit ra, wa;
        wr = w; w_data = d; rd = r; flush = f; err_clr = e;
        #1;
        check_all();
        @(posedge clk);
        if (f) begin
            q.delete();
            m_v0 = 1'b0;
            if (e) begin m_ovf = 1'b0; m_unf = 1'b0; end
        end else begin
            ra = r && (q.size() > 0);
            wa = w && ((q.size() < DEPTH) || ra);
            if (ra) begin
                m_d0 = q.pop_front();
                m_v0 = 1'b1;
            end else begin
                m_v0 = 1'b0;
            end
            if (wa) q.push_back(d);
            if (w && !wa) m_ovf = 1'b1; else if (e) m_ovf = 1'b0;
            if (r && !ra) m_unf = 1'b1; else if (e) m_unf = 1'b0;
        end
        @(negedge clk);
    endtask

    initial begin
        rst_n = 1'b0; flush = 1'b0; wr = 1'b0; w_data = '0; rd = 1'b0;
        th = 5'd5; err_clr = 1'b0;
        m_ovf = 1'b0; m_unf = 1'b0; m_v0 = 1'b0; m_d0 = '0;
        #1;
        check_all();
        @(negedge clk);
        rst_n = 1'b1;

        // Fill and drain
        for (int i = 0; i < 16; i++) cycle(1, 8'(i), 0, 0, 0);
        chk("fill_full",  32'(full1),  32'd1);
        chk("fill_level", 32'(level1), 32'd16);

        // Full boundary: rejected write, then simultaneous read+write
        cycle(1, 8'hAA, 0, 0, 0);
        chk("full_ovf", 32'(ovf1), 32'd1);
        cycle(1, 8'h55, 1, 0, 0);
        chk("full_rw_level", 32'(level1), 32'd16);
        for (int i = 0; i < 16; i++) cycle(0, 8'h00, 1, 0, 0);

        // Empty boundary
        cycle(0, 8'h00, 0, 0, 1);
        cycle(1, 8'h3C, 1, 0, 0);
        chk("empty_rw_unf",   32'(unf1),   32'd1);
        chk("empty_rw_level", 32'(level1), 32'd1);
        cycle(0, 8'h00, 1, 0, 0);
        cycle(0, 8'h00, 0, 0, 1);
        cycle(0, 8'h00, 1, 0, 1);
        chk("clr_vs_set_unf", 32'(unf1), 32'd1);
        cycle(0, 8'h00, 0, 0, 1);

        // Thresholds at th=5
        th = 5'd5;
        for (int i = 0; i < 6; i++) cycle(1, 8'(8'hA0 + i), 0, 0, 0);
        chk("th_above", 32'(above1), 32'd1);
        cycle(0, 8'h00, 1, 0, 0);
        cycle(0, 8'h00, 1, 0, 0);
        chk("th_below", 32'(below1), 32'd1);

        // Flush, then pointer wrap, then flush with a write
        cycle(0, 8'h00, 0, 1, 0);
        for (int i = 0; i < 12; i++) cycle(1, 8'(8'h10 + i), 0, 0, 0);
        for (int i = 0; i < 10; i++) cycle(0, 8'h00, 1, 0, 0);
        for (int i = 0; i < 10; i++) cycle(1, 8'(8'h40 + i), 0, 0, 0);
        chk("wrap_level", 32'(level1), 32'd12);
        cycle(1, 8'hEE, 0, 1, 0);
        chk("flush_level", 32'(level1), 32'd0);
        chk("flush_ovf",   32'(ovf1),   32'd0);

        // Registered read port: back-to-back reads
        cycle(1, 8'h11, 0, 0, 0);
        cycle(1, 8'h22, 0, 0, 0);
        cycle(0, 8'h00, 1, 0, 0);
        cycle(0, 8'h00, 1, 0, 0);
        cycle(0, 8'h00, 0, 0, 0);
        chk("reg_hold_data",  32'(r_data0),  32'h22);
        chk("reg_hold_valid", 32'(r_valid0), 32'd0);

        // Randomised traffic
        for (int i = 0; i < 600; i++) begin
            bit w, r, f, e;
            th = 5'($urandom_range(0, 16));
            w  = (i < 300) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
            r  = (i < 300) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
            f  = ($urandom_range(0, 39) == 0);
            e  = ($urandom_range(0, 15) == 0);
            cycle(w, 8'($urandom), r, f, e);
        end

        // Asynchronous reset mid-stream
        cycle(1, 8'h77, 0, 0, 0);
        cycle(1, 8'h88, 0, 0, 0);
        cycle(0, 8'h00, 1, 0, 0);
        #2;
        rst_n = 1'b0;
        wr = 1'b1; rd = 1'b0; flush = 1'b0; err_clr = 1'b0; w_data = 8'h99;
        #1;
        chk("rst_r_valid_reg", 32'(r_valid0), 32'd0);
        chk("rst_r_data_reg",  32'(r_data0),  32'd0);
        chk("rst_level",       32'(level1),   32'd0);
        chk("rst_empty",       32'(empty1),   32'd1);
        q.delete(); m_ovf = 1'b0; m_unf = 1'b0; m_v0 = 1'b0; m_d0 = '0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        cycle(0, 8'h00, 0, 0, 0);
        cycle(1, 8'h5A, 0, 0, 0);
        cycle(0, 8'h00, 1, 0, 0);
        cycle(0, 8'h00, 0, 0, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/usb_cdc_fifo_ex.md
Name: usb_cdc_fifo_ex

Overview:
Parametrised synchronous FIFO for the USB CDC data path. It is the next-generation buffer between the usb_cdc core bulk endpoints and the bus-side register interface, and replaces the fixed 16-entry FIFO.
- Adds a full-depth level count, threshold flags, synchronous flush and sticky overflow/underflow errors.
- Adds a selectable read mode: first-word-fall-through (FWFT) or registered.
- Defines correct simultaneous read/write behaviour at the empty and full boundaries.

Parameters:
DW, 8, data width in bits.
AW, 4, address width; DEPTH = 2**AW entries (AW >= 1).
FWFT, 1, read mode. 1 = head word visible combinationally on r_data. 0 = r_data is registered and updated one cycle after an accepted read.

Ports:
clk  input  1  clock; all logic on the rising edge.
rst_n  input  1  asynchronous active-low reset.
flush  input  1  synchronous clear of FIFO contents.
wr  input  1  write request.
w_data  input  DW  write data.
rd  input  1  read request.
r_data  output  DW  read data.
r_valid  output  1  read data valid.
empty  output  1  FIFO holds 0 entries.
full  output  1  FIFO holds DEPTH entries.
level  output  AW+1  current entry count, 0..DEPTH.
th  input  AW+1  threshold for the level flags.
level_above  output  1  level > th.
level_below  output  1  level < th.
overflow  output  1  sticky: a write was rejected.
underflow  output  1  sticky: a read was rejected.
err_clr  input  1  clears overflow and underflow.

Behaviour:
- Interface: one clock, clk; reset rst_n is asynchronous and active-low.
- Reset values:
  - level=0, empty=1, full=0, overflow=0, underflow=0, write/read pointers=0.
  - FWFT=0: r_valid=0, r_data=0.
  - FWFT=1: r_valid=0 (tracks ~empty); r_data is don't-care until the first write.
  - Memory contents are not reset.
- Acceptance rules:
  - rd_acc = rd & ~empty.
  - wr_acc = wr & (~full | rd_acc). A write while full is accepted only together with an accepted read.
- Pointers and level:
  - Write pointer advances on wr_acc; memory[wptr] <= w_data on the same edge.
  - Read pointer advances on rd_acc.
  - Pointers wrap modulo DEPTH.
  - level_next = level + wr_acc - rd_acc.
  - empty = (level==0); full = (level==DEPTH). Both are derived from registered state, never combinationally from wr/rd.
- Boundary cases:
  - Empty with rd & wr: the read is rejected (underflow sets) and the write is accepted; level goes 0->1. Write data is never passed through in the same cycle.
  - Full with rd & wr: both are accepted; level stays DEPTH and full stays 1.
  - Full with wr only: write rejected, overflow sets, contents unchanged.
- Flush:
  - Highest priority. On the edge where flush=1: pointers=0, level=0, empty=1, full=0.
  - wr and rd in the flush cycle are ignored and set no error flags.
  - overflow and underflow are unaffected by flush.
  - FWFT=0: r_valid=0 in the cycle after flush; r_data holds its value.
- Error flags:
  - overflow sets on wr & ~wr_acc & ~flush; underflow sets on rd & ~rd_acc & ~flush.
  - err_clr clears both flags; a set condition in the same cycle wins over err_clr.
- Threshold flags: level_above and level_below are combinational from the registered level and th, using unsigned compares. With th=0, level_below is always 0. With th=DEPTH, level_above is always 0.
- Read mode FWFT=1: r_data = memory[rptr] combinationally; r_valid = ~empty. Zero-cycle read latency; rd acknowledges the currently displayed word.
- Read mode FWFT=0:
  - On rd_acc, r_data <= memory[rptr] and r_valid <= 1 for exactly one cycle. Latency is 1 cycle.
  - r_data holds its last value otherwise.
  - Back-to-back accepted reads give r_valid high on consecutive cycles.
- Reset mid-operation: asserting rst_n low at any time forces all reset values asynchronously; no partial transfer completes.

Test Plan:
- Fill/drain (DW=8, AW=4, FWFT=1): write 0x00..0x0F -> full=1 and level=16 after the 16th edge; read 16 times -> data 0x00..0x0F in order, then empty=1, level=0, no errors.
- Full boundary: with the FIFO full, wr=1/rd=0 with 0xAA -> overflow=1, level=16, 0xAA absent on drain; then rd=1 & wr=1 with 0x55 -> level stays 16, and 0x55 is the last word drained.
- Empty boundary: on an empty FIFO, rd=1 & wr=1 with 0x3C -> underflow=1, level=1; next read returns 0x3C. Then err_clr=1 -> both flags 0; err_clr together with an illegal rd -> underflow stays 1.
- Thresholds: th=5; write 5 words -> level_below=0, level_above=0; sixth write -> level_above=1; read 2 -> level=4, level_below=1.
- Flush and wrap: write 12, read 10, write 10 (pointer wrap), check level=12 and order; assert flush together with wr=1 -> level=0, empty=1, no overflow, written word discarded.
- FWFT=0 mode: write 0x11, 0x22; rd on 2 consecutive cycles -> r_valid high on the following 2 cycles with r_data=0x11 then 0x22; r_data holds 0x22 afterwards; async reset mid-stream -> r_valid=0, r_data=0, level=0 immediately.
